// File: rtl/mfm_sync_decoder_if.sv
// MFM decoder bus: PLL-side inputs (flux, cell clock, lock) and decoded outputs.
interface mfm_sync_decoder_if;
    logic       dout;
    logic       cout;
    logic       lck;
    logic [7:0] data;
    logic       data_valid;
    logic       sync;
    logic       in_frame;
    logic       mfm_err;

    modport master (
        output dout, cout, lck,
        input  data, data_valid, sync, in_frame, mfm_err
    );

    modport slave (
        input  dout, cout, lck,
        output data, data_valid, sync, in_frame, mfm_err
    );
endinterface

// File: rtl/mfm_sync_decoder.sv
// MFM cell sampler, sync-word hunter and byte decoder.
// Define MFM_SYNC_ERR_EN to flag MFM coding violations in DATA and drop back to HUNT.
module mfm_sync_decoder #(
    parameter logic [15:0] SYNC_WORD  = 16'h4489,
    parameter int          BYTE_LIMIT = 1088
) (
    input  logic               clk,
    input  logic               rst,
    mfm_sync_decoder_if.slave  bus
);
    localparam int BCW = $clog2(BYTE_LIMIT + 1);

    typedef enum logic {HUNT, DATA} state_t;

    state_t           state_q, state_d;
    logic [2:0]       dout_sr, cout_sr;
    logic [1:0]       lck_sr;
    logic             pulse_seen;
    logic [15:0]      raw_q, raw_nxt;
    logic [3:0]       cell_cnt_q, cell_cnt_d;
    logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [7:0]       data_q, data_nxt;
    logic             dv_q, sync_q, dv_d, sync_d;
    logic             cell_edge, dout_rise, cell_val, sync_hit, locked;

    // stage 3 exists only for edge detection on the synchronized value
    assign cell_edge = cout_sr[1] & ~cout_sr[2];
    assign dout_rise = dout_sr[1] & ~dout_sr[2];
    assign locked    = lck_sr[1];
    assign cell_val  = pulse_seen | dout_rise;
    assign raw_nxt   = {raw_q[14:0], cell_val};
    assign sync_hit  = (raw_nxt == SYNC_WORD);

    always_comb begin
        data_nxt = 8'h00;
        for (int i = 0; i < 8; i++) data_nxt[i] = raw_nxt[2*i];
    end

`ifdef MFM_SYNC_ERR_EN
    logic err_q, err_d, viol;
    assign viol = (raw_nxt[1:0] == 2'b11) || (raw_nxt[3:0] == 4'b0000);
`endif

    always_comb begin
        state_d    = state_q;
        cell_cnt_d = cell_cnt_q;
        byte_cnt_d = byte_cnt_q;
        sync_d     = 1'b0;
        dv_d       = 1'b0;
`ifdef MFM_SYNC_ERR_EN
        err_d      = 1'b0;
`endif
        if (!locked) begin
            state_d    = HUNT;
            cell_cnt_d = 4'd0;
            byte_cnt_d = '0;
        end else if (cell_edge) begin
            case (state_q)
                HUNT: begin
                    if (sync_hit) begin
                        sync_d     = 1'b1;
                        state_d    = DATA;
                        cell_cnt_d = 4'd0;
                        byte_cnt_d = '0;
                    end
                end
                DATA: begin
                    if (sync_hit) begin
                        sync_d     = 1'b1;
                        cell_cnt_d = 4'd0;
`ifdef MFM_SYNC_ERR_EN
                    end else if (viol) begin
                        err_d      = 1'b1;
                        state_d    = HUNT;
                        cell_cnt_d = 4'd0;
`endif
                    end else begin
                        cell_cnt_d = cell_cnt_q + 4'd1;
                        if (cell_cnt_q == 4'd15) begin
                            dv_d       = 1'b1;
                            byte_cnt_d = byte_cnt_q + 1'b1;
                            // last permitted byte leaves DATA on the same edge it is strobed
                            if (byte_cnt_q == BCW'(BYTE_LIMIT - 1)) state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HUNT;
            dout_sr    <= 3'b000;
            cout_sr    <= 3'b000;
            lck_sr     <= 2'b00;
            pulse_seen <= 1'b0;
            raw_q      <= 16'h0000;
            cell_cnt_q <= 4'd0;
            byte_cnt_q <= '0;
            data_q     <= 8'h00;
            dv_q       <= 1'b0;
            sync_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dout_sr    <= {dout_sr[1:0], bus.dout};
            cout_sr    <= {cout_sr[1:0], bus.cout};
            lck_sr     <= {lck_sr[0], bus.lck};
            cell_cnt_q <= cell_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            dv_q       <= dv_d;
            sync_q     <= sync_d;
            if (dv_d) data_q <= data_nxt;
            if (cell_edge) begin
                raw_q      <= raw_nxt;
                pulse_seen <= 1'b0;
            end else if (dout_rise) begin
                pulse_seen <= 1'b1;
            end
        end
    end

`ifdef MFM_SYNC_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
    assign bus.mfm_err = err_q;
`else
    assign bus.mfm_err = 1'b0;
`endif

    assign bus.data       = data_q;
    assign bus.data_valid = dv_q;
    assign bus.sync       = sync_q;
    assign bus.in_frame   = (state_q == DATA);
endmodule

// File: doc/mfm_sync_decoder.md
MFM_SYNC_DECODER -- requirements
Module: mfm_sync_decoder

Interface
REQ-001 Parameter SYNC_WORD, default 16'h4489, raw MFM cell pattern that marks a sync mark.
REQ-002 Parameter BYTE_LIMIT, default 1088, decoded bytes accepted per sync before returning to hunt.
REQ-003 Port clk  input  1  sole system clock, 32 MHz nominal; all state in this module is on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port dout  input  1  conditioned MFM flux pulses from the PLL stage; asynchronous to clk.
REQ-006 Port cout  input  1  recovered cell clock from the PLL stage, 500 kHz nominal; asynchronous to clk.
REQ-007 Port lck  input  1  PLL lock indication; asynchronous to clk.
REQ-008 Port data  output  8  last decoded data byte, MSB first.
REQ-009 Port data_valid  output  1  one-cycle strobe, data is new.
REQ-010 Port sync  output  1  one-cycle strobe, SYNC_WORD matched.
REQ-011 Port in_frame  output  1  high while the state machine is in DATA.
REQ-012 Port mfm_err  output  1  one-cycle strobe, MFM coding violation detected.

Function
REQ-013 dout, cout and lck each SHALL pass through a two-flop synchronizer before use.
REQ-014 Cell edge: synchronized cout rising (stage2 high, stage3 low); clk SHALL be at least 8x the cout frequency.
REQ-015 pulse_seen SHALL set on a synchronized dout rising edge and clear on each cell edge; a pulse edge coincident with a cell edge counts toward the cell being closed.
REQ-016 On each cell edge, the closed cell value (pulse_seen OR coincident pulse) SHALL shift into the LSB of a 16-bit raw register.
REQ-017 FSM states: HUNT (reset state), DATA.
REQ-018 HUNT: when the raw register equals SYNC_WORD after a shift, sync SHALL pulse one clk later, the FSM SHALL enter DATA, and the cell and byte counters SHALL clear.
REQ-019 DATA: a 4-bit cell counter SHALL wrap every 16 cells; on wrap, data SHALL load the 8 odd-position cells (raw bits 14,12,...,0) and data_valid SHALL pulse one clk after the 16th shift.
REQ-020 DATA: a raw register equal to SYNC_WORD SHALL pulse sync and realign (clear the cell counter, no byte emitted); consecutive sync words are legal.
REQ-021 DATA: after BYTE_LIMIT bytes have been emitted, the FSM SHALL return to HUNT on the same cycle as the last data_valid.
REQ-022 Synchronized lck low SHALL force HUNT within 1 clk in any state; a partial byte is discarded.
REQ-023 in_frame SHALL equal (state == DATA), registered.
REQ-024 The byte counter SHALL be $clog2(BYTE_LIMIT+1) bits wide and SHALL never wrap.
REQ-025 sync and data_valid SHALL never be high on the same cycle; a sync match takes priority.

Reset
REQ-026 While rst is high: state HUNT, all synchronizers, raw register, counters and pulse_seen 0; data 8'h00; data_valid, sync, in_frame and mfm_err 0.
REQ-027 Reset asserted mid-byte SHALL discard all partial state; no strobe SHALL fire in the first 3 clks after release.

Configuration
REQ-028 Macro MFM_SYNC_ERR_EN defined: in DATA, two consecutive 1 cells, or more than three consecutive 0 cells, SHALL pulse mfm_err and force HUNT.
REQ-029 Macro MFM_SYNC_ERR_EN undefined: mfm_err SHALL be tied 0 and violations SHALL be ignored; sync patterns themselves SHALL never flag an error.

Verification
REQ-030 Stream raw 0xAAAA, then 0x4489 with lck=1 -> exactly one sync pulse, in_frame=1.
REQ-031 After sync, raw cells 0x5555 -> data=8'hFF, data_valid pulses once; raw cells 0xAAAA -> data=8'h00.
REQ-032 BYTE_LIMIT=4: sync, then 5 encoded bytes -> exactly 4 data_valid pulses, then in_frame=0.
REQ-033 Drop lck mid-byte, re-lock, resend 0x4489 -> no data_valid before the new sync; counting restarts at 0.
REQ-034 MFM_SYNC_ERR_EN defined: inject cells 1,1 in DATA -> mfm_err pulses and in_frame falls; undefined -> no error pulse and decoding continues.
REQ-035 Assert rst mid-byte for 2 clks -> all outputs 0 and state HUNT; a following 0x4489 yields a normal sync.
